entity_line_rasterizer: RTL

ENTITY_LINE_RASTERIZER -- requirements
Module: entity_line_rasterizer

---
 rtl/squares_pkg.sv | 45 ++++
 rtl/entity_line_rasterizer_if.sv | 10 +
 rtl/line_buffer_pp.sv | 37 +++
 rtl/entity_line_rasterizer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/squares_pkg.sv
// Shared constants, state type and paint-mask helper for the entity line rasterizer.
package squares_pkg;

  localparam int unsigned SCREEN_W  = 480;
  localparam int unsigned CELL_PX   = 48;
  localparam int unsigned SEG_W     = 16;
  localparam int unsigned NUM_SEGS  = 30;
  localparam int unsigned SEG_BITS  = 4;
  localparam int unsigned SEG_IDX_W = 5;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned ENT_IDX_W = 8;
  localparam int unsigned ENT_REC_W = 21;

  // Entity record layout {code, row, col}
  localparam int unsigned ENT_CODE_MSB = 20;
  localparam int unsigned ENT_CODE_LSB = 18;
  localparam int unsigned ENT_ROW_MSB  = 17;
  localparam int unsigned ENT_ROW_LSB  = 9;
  localparam int unsigned ENT_COL_MSB  = 8;
  localparam int unsigned ENT_COL_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_TEST,
    ST_PAINT
  } ras_state_e;

  // Pixels of segment seg that fall inside [first, last]
  function automatic logic [SEG_W-1:0] seg_mask(input logic [SEG_IDX_W-1:0] seg,
                                                input logic [X_W-1:0]       first,
                                                input logic [X_W-1:0]       last);
    logic [X_W-1:0] px;
    seg_mask = '0;
    for (int i = 0; i < SEG_W; i++) begin
      px = {seg, SEG_BITS'(i)};
      seg_mask[i] = (px >= first) && (px <= last);
    end
  endfunction

endpackage

// File: rtl/entity_line_rasterizer_if.sv
// Entity-memory read bus: address out from the rasterizer, record back one cycle later.
interface entity_line_rasterizer_if
  import squares_pkg::*;
;
  logic [ENT_IDX_W-1:0] ent_rd_addr;
  logic [ENT_REC_W-1:0] ent_rd_data;

  modport master (output ent_rd_addr, input ent_rd_data);
  modport slave  (input ent_rd_addr, output ent_rd_data);
endinterface

// File: rtl/line_buffer_pp.sv
// Ping-pong line store: segment-masked write into the build half, registered read of the display half.
module line_buffer_pp
  import squares_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 swap,
  input  logic                 wr_en,
  input  logic [SEG_IDX_W-1:0] wr_seg,
  input  logic [SEG_W-1:0]     wr_mask,
  input  logic [PIX_W-1:0]     wr_pix,
  input  logic [X_W-1:0]       rd_x,
  output logic [PIX_W-1:0]     rd_pix
);

  logic [1:0][NUM_SEGS-1:0][SEG_W-1:0][PIX_W-1:0] mem;
  logic                                           sel;

  // sel names the display half; the build half is ~sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      sel    <= 1'b0;
      rd_pix <= '0;
    end else begin
      if (swap) sel <= ~sel;
      if (wr_en) begin
        for (int i = 0; i < SEG_W; i++) begin
          if (wr_mask[i]) mem[~sel][wr_seg][i] <= wr_pix;
        end
      end
      if (rd_x < X_W'(SCREEN_W)) rd_pix <= mem[sel][rd_x[X_W-1:SEG_BITS]][rd_x[SEG_BITS-1:0]];
      else                       rd_pix <= '0;
    end
  end

endmodule

// File: rtl/entity_line_rasterizer.sv
// Builds one 480-pixel line of 48x48 entity squares per line_start into a ping-pong buffer.
// Optional sticky overrun flag enabled by defining ENT_RASTER_OVERRUN_EN.
module entity_line_rasterizer
  import squares_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [Y_W-1:0]                line_y,
  input  logic [ENT_IDX_W-1:0]          entities_number,
  entity_line_rasterizer_if.master      ent_bus,
  input  logic [X_W-1:0]                pix_x,
  output logic [CODE_W-1:0]             pix_code,
  output logic                          pix_valid,
  output logic                          busy
`ifdef ENT_RASTER_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  ras_state_e             state_q, state_d;
  logic [Y_W-1:0]         line_y_q;
  logic [ENT_IDX_W-1:0]   ent_num_q;
  logic [ENT_IDX_W-1:0]   idx_q, idx_d, next_idx;
  logic [ENT_IDX_W-1:0]   addr_q, addr_d;
  logic [SEG_IDX_W-1:0]   seg_q, seg_d, seg_last_q, seg_last_d;
  logic [X_W-1:0]         col_q, col_d, last_q, last_d;
  logic [CODE_W-1:0]      code_q, code_d;
  logic                   busy_d;

  logic [ENT_REC_W-1:0]   rec;
  logic [CODE_W-1:0]      rec_code;
  logic [Y_W-1:0]         rec_row;
  logic [X_W-1:0]         rec_col;
  logic [X_W:0]           row_end, last_sum;
  logic [X_W-1:0]         rec_last;
  logic                   hit;

  logic                   wr_en_c;
  logic [SEG_W-1:0]       wr_mask_c;
  logic [PIX_W-1:0]       wr_pix_c;
  logic [PIX_W-1:0]       rd_pix;

  assign rec      = ent_bus.ent_rd_data;
  assign rec_code = rec[ENT_CODE_MSB:ENT_CODE_LSB];
  assign rec_row  = rec[ENT_ROW_MSB:ENT_ROW_LSB];
  assign rec_col  = rec[ENT_COL_MSB:ENT_COL_LSB];

  // Row window is a 10-bit sum so rows near 511 never wrap into a false hit
  assign row_end  = {1'b0, rec_row} + (X_W+1)'(CELL_PX);
  assign hit      = (line_y_q >= rec_row) && ({1'b0, line_y_q} < row_end) &&
                    (rec_col < X_W'(SCREEN_W));
  assign last_sum = {1'b0, rec_col} + (X_W+1)'(CELL_PX - 1);
  assign rec_last = (last_sum > (X_W+1)'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : last_sum[X_W-1:0];
  assign next_idx = idx_q + ENT_IDX_W'(1);

  // Next-state, datapath and buffer write control
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    seg_d      = seg_q;
    seg_last_d = seg_last_q;
    col_d      = col_q;
    last_d     = last_q;
    code_d     = code_q;
    wr_en_c    = 1'b0;
    wr_mask_c  = '0;
    wr_pix_c   = '0;

    case (state_q)
      ST_CLEAR: begin
        wr_en_c   = 1'b1;
        wr_mask_c = '1;
        if (seg_q == SEG_IDX_W'(NUM_SEGS - 1)) begin
          idx_d   = '0;
          addr_d  = '0;
          state_d = (ent_num_q == '0) ? ST_IDLE : ST_FETCH;
        end else begin
          seg_d = seg_q + SEG_IDX_W'(1);
        end
      end
      ST_FETCH: state_d = ST_TEST;
      ST_TEST: begin
        if (hit) begin
          state_d    = ST_PAINT;
          col_d      = rec_col;
          last_d     = rec_last;
          code_d     = rec_code;
          seg_d      = rec_col[X_W-1:SEG_BITS];
          seg_last_d = rec_last[X_W-1:SEG_BITS];
        end else begin
          idx_d   = next_idx;
          addr_d  = next_idx;
          state_d = (next_idx == ent_num_q) ? ST_IDLE : ST_FETCH;
        end
      end
      ST_PAINT: begin
        wr_en_c   = 1'b1;
        wr_mask_c = seg_mask(seg_q, col_q, last_q);
        wr_pix_c  = {1'b1, code_q};
        if (seg_q == seg_last_q) begin
          idx_d   = next_idx;
          addr_d  = next_idx;
          state_d = (next_idx == ent_num_q) ? ST_IDLE : ST_FETCH;
        end else begin
          seg_d = seg_q + SEG_IDX_W'(1);
        end
      end
      default: ;
    endcase

    // A new line always wins, abandoning any build in flight
    if (line_start) begin
      state_d = ST_CLEAR;
      seg_d   = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_y_q   <= '0;
      ent_num_q  <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      seg_q      <= '0;
      seg_last_q <= '0;
      col_q      <= '0;
      last_q     <= '0;
      code_q     <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      seg_q      <= seg_d;
      seg_last_q <= seg_last_d;
      col_q      <= col_d;
      last_q     <= last_d;
      code_q     <= code_d;
      busy       <= busy_d;
      if (line_start) begin
        line_y_q  <= line_y;
        ent_num_q <= entities_number;
      end
    end
  end

`ifdef ENT_RASTER_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     overrun <= 1'b0;
    else if (line_start && busy) overrun <= 1'b1;
  end
`endif

  assign ent_bus.ent_rd_addr = addr_q;

  line_buffer_pp u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .swap    (line_start),
    .wr_en   (wr_en_c),
    .wr_seg  (seg_q),
    .wr_mask (wr_mask_c),
    .wr_pix  (wr_pix_c),
    .rd_x    (pix_x),
    .rd_pix  (rd_pix)
  );

  assign pix_valid = rd_pix[PIX_W-1];
  assign pix_code  = rd_pix[CODE_W-1:0];

endmodule
